// File: rtl/seg7_pkg.sv
// seg7_pkg: 7-segment pattern constants, the capture-state encoding and
// the settle-counter width shared by the display monitors.
package seg7_pkg;

  // Segment order is {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  typedef enum logic [1:0] {WAIT, SETTLE, HELD} cap_state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational 7-segment pattern to BCD decoder.
// legal is low for any pattern that is not one of the ten digit glyphs.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] bcd
);

  // Map each glyph back to its digit value.
  always_comb begin
    legal = 1'b1;
    bcd   = 4'd0;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_to_bcd_capture.sv
// seg7_to_bcd_capture: samples a multiplexed 7-segment display, filters each
// strobed pattern for stability, decodes it and assembles full frames of BCD
// digits behind a one-entry valid/ready buffer.
// Optional feature: define SEG7_ERR_CNT_EN to add the saturating err_cnt port.
module seg7_to_bcd_capture
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a,
  input  logic                  b,
  input  logic                  c,
  input  logic                  d,
  input  logic                  e,
  input  logic                  f,
  input  logic                  g,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err,
  output logic [2:0]            err_digit,
  output logic                  overrun
`ifdef SEG7_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);

  function automatic logic [2:0] onehot_idx(input logic [DIGITS-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < DIGITS; i++)
      if (v[i]) idx = idx | 3'(i);
    return idx;
  endfunction

`ifdef SEG7_ERR_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  logic [6:0]        seg_p0, seg_p1;
  logic [DIGITS-1:0] dig_p0, dig_p1;
  logic              dec_legal;
  logic [3:0]        dec_bcd;
  logic              one_hot, change;
  cap_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_run;
  logic              accept;
  logic              vld_p1, legal_p1;
  logic [3:0]        bcd_p1;
  logic [DIGITS-1:0] sel_p1;
  logic [2:0]        idx_p1;
  logic [3:0]        slot [DIGITS];
  logic [DIGITS-1:0] seen, seen_nxt;
  logic [4*DIGITS-1:0] frame_flat;
  logic              frame_done, buf_free;

  // ---- stage p0: input sample, p1 holds the previous sample for change detect
  // Strobe sample registers feed the FSM, so they are cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_p0 <= '0;
      dig_p1 <= '0;
    end else begin
      dig_p0 <= dig_en;
      dig_p1 <= dig_p0;
    end
  end

  // Segment sample registers carry data only.
  always_ff @(posedge clk) begin
    seg_p0 <= {a, b, c, d, e, f, g};
    seg_p1 <= seg_p0;
  end

  seg7_pattern_decode u_dec (
    .seg   (seg_p0),
    .legal (dec_legal),
    .bcd   (dec_bcd)
  );

  assign one_hot = (dig_p0 != '0) && ((dig_p0 & (dig_p0 - DIGITS'(1))) == '0);
  assign change  = (dig_p0 != dig_p1) || (seg_p0 != seg_p1);

  // Stability filter: count identical one-hot samples, accept once per run.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cnt_run   = CNT_W'(1);
    accept    = 1'b0;
    if (!one_hot) begin
      state_nxt = WAIT;
      cnt_nxt   = '0;
    end else if (!(state == HELD && !change)) begin
      cnt_run = (state == SETTLE && !change) ? cnt + CNT_W'(1) : CNT_W'(1);
      cnt_nxt = cnt_run;
      if (cnt_run == STABLE_N) begin
        accept    = 1'b1;
        state_nxt = HELD;
      end else begin
        state_nxt = SETTLE;
      end
    end
  end

  // FSM state and settle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---- stage p1: registered accept
  // Accept strobe is control and is reset; the payload travels unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= accept;
  end

  // Accept payload: decoded digit, legality and strobe position.
  always_ff @(posedge clk) begin
    legal_p1 <= dec_legal;
    bcd_p1   <= dec_bcd;
    sel_p1   <= dig_p0;
    idx_p1   <= onehot_idx(dig_p0);
  end

  // ---- stage p2: capture slots, frame assembly and output buffer
  // Legal accepts overwrite their slot; the last value before completion wins.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DIGITS; i++)
      if (vld_p1 && legal_p1 && sel_p1[i]) slot[i] <= bcd_p1;
  end

  // Completion clears seen first so an accept on the same edge starts the next frame.
  always_comb begin
    seen_nxt = frame_done ? '0 : seen;
    for (int i = 0; i < DIGITS; i++)
      if (vld_p1 && sel_p1[i]) seen_nxt[i] = legal_p1;
  end

  // Flatten slots into the frame word, nibble i = digit i.
  always_comb begin
    frame_flat = '0;
    for (int i = 0; i < DIGITS; i++)
      frame_flat[4*i +: 4] = slot[i];
  end

  assign frame_done = &seen;
  assign buf_free   = !out_valid || out_ready;

  // Output buffer, error pulse and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen      <= '0;
      bcd_out   <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      err_digit <= 3'd0;
      overrun   <= 1'b0;
`ifdef SEG7_ERR_CNT_EN
      err_cnt   <= 8'd0;
`endif
    end else begin
      seen <= seen_nxt;
      err  <= vld_p1 && !legal_p1;
      if (vld_p1 && !legal_p1) begin
        err_digit <= idx_p1;
`ifdef SEG7_ERR_CNT_EN
        err_cnt   <= sat_inc(err_cnt);
`endif
      end
      if (frame_done) begin
        if (buf_free) begin
          bcd_out   <= frame_flat;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_to_bcd_capture.sv
// Testbench for seg7_to_bcd_capture (DIGITS=4, STABLE_CYCLES=3).
// With SEG7_ERR_CNT_EN defined it also exercises err_cnt saturation.
module tb_seg7_to_bcd_capture;
  import seg7_pkg::*;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a, b, c, d, e, f, g;
  logic [3:0]  dig_en;
  logic [15:0] bcd_out;
  logic        out_valid, out_ready, err, overrun;
  logic [2:0]  err_digit;
`ifdef SEG7_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  seg7_to_bcd_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .dig_en    (dig_en),
    .bcd_out   (bcd_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .err_digit (err_digit),
    .overrun   (overrun)
`ifdef SEG7_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Bench-owned glyph table, {a..g}
  logic [6:0] pat [10];
  localparam logic [6:0] BAD_A = 7'b0111111;
  localparam logic [6:0] BAD_B = 7'b0000001;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  logic [2:0] last_err_dig = 3'd0;

  // Count err pulses as seen at each rising edge.
  always @(posedge clk) begin
    if (err) begin
      err_pulses   <= err_pulses + 1;
      last_err_dig <= err_digit;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one strobe/pattern (d<0 blanks strobes) for n cycles.
  task automatic show(input int dg, input logic [6:0] p, input int n);
    dig_en = (dg < 0) ? 4'b0000 : 4'(1 << dg);
    {a, b, c, d, e, f, g} = p;
    step(n);
  endtask

  typedef struct {
    logic [3:0] dg [4];
    logic [15:0] exp;
  } frame_t;
  frame_t tbl [4];

  initial begin
    int e0;
    pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101;
    pat[3] = 7'b1111001; pat[4] = 7'b0110011; pat[5] = 7'b1011011;
    pat[6] = 7'b1011111; pat[7] = 7'b1110000; pat[8] = 7'b1111111;
    pat[9] = 7'b1111011;

    tbl[0].dg = '{4'd1, 4'd2, 4'd3, 4'd4}; tbl[0].exp = 16'h4321;
    tbl[1].dg = '{4'd0, 4'd1, 4'd2, 4'd3}; tbl[1].exp = 16'h3210;
    tbl[2].dg = '{4'd4, 4'd5, 4'd6, 4'd7}; tbl[2].exp = 16'h7654;
    tbl[3].dg = '{4'd8, 4'd9, 4'd0, 4'd5}; tbl[3].exp = 16'h5098;

    rst_n = 1'b0;
    out_ready = 1'b1;
    dig_en = 4'b0000;
    {a, b, c, d, e, f, g} = 7'b0000000;
    step(2);
    check("reset_bcd_out",   32'(bcd_out),   32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_err",       32'(err),       32'h0);
    check("reset_overrun",   32'(overrun),   32'h0);
    rst_n = 1'b1;
    step(1);

    // Table-driven frames with exact completion latency
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 4; k++) show(k, pat[tbl[t].dg[k]], 5);
      check("frame_not_early", 32'(out_valid), 32'h0);
      step(1);
      check("frame_valid", 32'(out_valid), 32'h1);
      check("frame_data",  32'(bcd_out),   32'(tbl[t].exp));
      step(1);
      check("frame_consumed", 32'(out_valid), 32'h0);
    end
    check("no_err_legal", 32'(err_pulses), 32'h0);

    // Invalid stable pattern on digit 2 after a short glitch
    show(0, pat[5], 5);
    show(1, pat[6], 5);
    show(2, pat[3], 2);
    show(2, BAD_A, 3);
    show(3, pat[9], 5);
    check("no_frame_after_err", 32'(out_valid), 32'h0);
    check("err_pulse_count", 32'(err_pulses), 32'h1);
    check("err_digit_value", 32'(last_err_dig), 32'h2);
    show(2, pat[7], 5);
    step(1);
    check("repair_valid", 32'(out_valid), 32'h1);
    check("repair_data",  32'(bcd_out),   32'h9765);
    step(1);

    // Back-pressure across two frames
    out_ready = 1'b0;
    show(0, pat[8], 5); show(1, pat[0], 5); show(2, pat[2], 5); show(3, pat[9], 5);
    step(1);
    check("bp_first_valid",   32'(out_valid), 32'h1);
    check("bp_first_data",    32'(bcd_out),   32'h9208);
    check("bp_no_overrun",    32'(overrun),   32'h0);
    for (int k = 0; k < 4; k++) show(k, pat[1], 5);
    step(1);
    check("bp_held_valid", 32'(out_valid), 32'h1);
    check("bp_held_data",  32'(bcd_out),   32'h9208);
    check("bp_overrun",    32'(overrun),   32'h1);
    out_ready = 1'b1;
    step(1);
    check("bp_drain", 32'(out_valid), 32'h0);
    check("overrun_sticky", 32'(overrun), 32'h1);

    // Non-one-hot strobes never accept
    e0 = err_pulses;
    dig_en = 4'b0110;
    {a, b, c, d, e, f, g} = BAD_B;
    step(10);
    check("multi_strobe_state", 32'(dut.state), 32'(WAIT));
    check("multi_strobe_no_err", 32'(err_pulses), 32'(e0));
    check("multi_strobe_no_frame", 32'(out_valid), 32'h0);

    // Reset mid-frame, then a fresh scan starting from digit 3
    show(0, pat[4], 5); show(1, pat[4], 5); show(2, BAD_A, 4);
    show(2, pat[4], 5);
    dig_en = 4'b0000;
    rst_n = 1'b0;
    #1;
    check("mid_reset_bcd_out",   32'(bcd_out),   32'h0);
    check("mid_reset_overrun",   32'(overrun),   32'h0);
    check("mid_reset_err_digit", 32'(err_digit), 32'h0);
    check("mid_reset_valid",     32'(out_valid), 32'h0);
    step(2);
    rst_n = 1'b1;
    show(3, pat[1], 5);
    step(2);
    check("no_stale_frame", 32'(out_valid), 32'h0);
    show(0, pat[2], 5); show(1, pat[6], 5); show(2, pat[8], 5);
    step(1);
    check("fresh_valid", 32'(out_valid), 32'h1);
    check("fresh_data",  32'(bcd_out),   32'h1862);
    step(1);

`ifdef SEG7_ERR_CNT_EN
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) show(0, (i % 2 == 0) ? BAD_A : BAD_B, 4);
    step(3);
    check("err_cnt_saturate", 32'(err_cnt), 32'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_to_bcd_capture.md
# seg7_to_bcd_capture

Captures the segment lines and one-hot digit strobes of a multiplexed multi-digit 7-segment display and recovers the displayed BCD digits. It is the receive-side counterpart of the BCD-to-7-segment drivers: it decodes patterns back to BCD and qualifies each pattern with a stability filter. It assembles one nibble per digit into a frame and hands complete frames to a consumer through a valid/ready buffer. It is used as a board-level self-check and loopback monitor for display paths.

## Interface
- DIGITS, 4, number of display digits / strobe lines (1..8)
- STABLE_CYCLES, 3, consecutive identical samples required before a pattern is accepted (1..255)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- a, b, c, d, e, f, g  input  1 each  segment lines, active-high (1 = lit)
- dig_en  input  DIGITS  digit strobes, active-high; bit i selects digit i
- bcd_out  output  4*DIGITS  frame; nibble i (bits 4i+3:4i) = digit i
- out_valid  output  1  bcd_out holds an unconsumed frame
- out_ready  input  1  consumer accepts frame when out_valid & out_ready
- err  output  1  one-cycle pulse: stable pattern not a legal digit
- err_digit  output  3  strobe index for the current err pulse
- overrun  output  1  sticky: a completed frame was dropped
- err_cnt  output  8  saturating invalid-pattern count (SEG7_ERR_CNT_EN only)

One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- All inputs registered once; seg[6:0] = {a,b,c,d,e,f,g}. All logic below uses the registered sample.
- Legal patterns (seg[6:0]): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Anything else is invalid.
- FSM per sample:
  - WAIT: dig_en not one-hot. Any change in the sample re-evaluates the state.
  - SETTLE: count identical one-hot samples. Any change in {dig_en, seg} restarts the count at 1, or moves to WAIT if not one-hot. When count reaches STABLE_CYCLES, accept and go to HELD.
  - HELD: no further accepts until {dig_en, seg} changes. On change, go to SETTLE (count 1) or WAIT.
- Legal accept: write the nibble into capture slot i and set seen[i].
- Invalid accept: pulse err with err_digit = i, clear seen[i], leave slot i unchanged.
- seen all-ones sets frame_done. On the next edge:
  - If the buffer is free (out_valid=0, or out_valid & out_ready that cycle), load bcd_out, set out_valid, clear seen.
  - Otherwise drop the frame, set overrun, clear seen.
- out_valid clears on the out_valid & out_ready edge unless a new frame loads on the same edge. In that case it stays high with the new data.
- overrun clears only on reset.

## Timing
- Reset: bcd_out=0, out_valid=0, err=0, err_digit=0, overrun=0, err_cnt=0, seen=0, FSM=WAIT, count=0. Reset mid-frame discards partial captures.
- Inputs constant before edges e..e+STABLE_CYCLES-1: slot write/err pulse at edge e+STABLE_CYCLES+1 (includes input register).
- Final digit of a frame: out_valid high one edge after its slot write.
- STABLE_CYCLES=1: every changed one-hot sample is accepted.
- Re-accepting a digit before the frame completes overwrites its slot. Last value wins.

## Configuration
- SEG7_ERR_CNT_EN defined: err_cnt port and counter exist. Increments on each err pulse and saturates at 255.
- SEG7_ERR_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package seg7_pkg holds:
  - SEG_0..SEG_9 7-bit pattern constants (shared with the BCD-to-7-segment drivers).
  - capture-state enum {WAIT, SETTLE, HELD}.
  - count width constant (8).
- Sub-module seg7_pattern_decode: combinational seg[6:0] -> {legal, bcd[3:0]}. Reusable by other display monitors.

## Test plan
- DIGITS=4, STABLE_CYCLES=3; strobe digits 0..3 with patterns 1,2,3,4, each held 5 cycles -> one frame bcd_out=16'h4321, out_valid high, out_ready=1 clears it next edge.
- Digit 2 pattern glitches after 2 samples, then holds 0111111 for 3 samples -> err pulse with err_digit=2, no frame; a later legal 7 on digit 2 completes the frame with nibble 2 = 7.
- out_ready=0 held across two full frames -> first frame retained unchanged, overrun=1, second frame dropped.
- dig_en=4'b0110 for 10 cycles -> FSM stays WAIT, no accepts, no err.
- Reset asserted after 3 digits captured -> all outputs 0 immediately. The next full scan yields a fresh frame with no stale nibbles.
- SEG7_ERR_CNT_EN defined, 300 invalid accepts -> err_cnt=255.
